// File: rtl/fanout_fork_pkg.sv
// ---------------------------------------------------------------------------
// fanout_fork_pkg
//   Shared types, default sizes and helpers for the eager-fork controller.
//   cfg_state_t : configuration sequencer states (RUN, PEND)
//   all_done()  : true when every selected consumer has taken, or is taking,
//                 the current head token
// ---------------------------------------------------------------------------
package fanout_fork_pkg;

    localparam int NUM_OUT_DEF   = 6;
    localparam int DATA_W_DEF    = 17;
    localparam int BUF_DEPTH_DEF = 2;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } cfg_state_t;

    // A consumer is finished with the head token if it is not selected,
    // has already accepted it, or is accepting it this cycle.
    function automatic logic all_done(
        input logic [NUM_OUT_DEF-1:0] mask,
        input logic [NUM_OUT_DEF-1:0] accepted,
        input logic [NUM_OUT_DEF-1:0] ready
    );
        return &(~mask | accepted | ready);
    endfunction

endpackage

// File: rtl/fanout_fork_buf.sv
// ---------------------------------------------------------------------------
// fanout_fork_buf
//   Small input skid FIFO in front of the fork. DEPTH must be a power of two
//   so the pointers wrap by plain overflow.
//   Ports:
//     clk, rst      clock and asynchronous active-high reset
//     push, data_in write request and token (ignored when full or flushing)
//     pop           remove the head token (ignored when empty or flushing)
//     flush         empty the FIFO; wins over push and pop
//     full, empty   occupancy flags (registered state only)
//     head          head token; holds the last shown head while empty
// ---------------------------------------------------------------------------
module fanout_fork_buf #(
    parameter int DATA_W = 17,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] last_head;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign do_push = push & ~full  & ~flush;
    assign do_pop  = pop  & ~empty & ~flush;

    // While empty the broadcast bus keeps showing the most recent head so
    // consumers never see a glitching data bus between tokens.
    assign head = empty ? last_head : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_head <= '0;
        end else begin
            if (!empty) begin
                last_head <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                // Simultaneous push and pop leaves the occupancy unchanged.
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: rtl/fanout_fork_ctrl.sv
// ---------------------------------------------------------------------------
// fanout_fork_ctrl
//   Eager-fork controller: broadcasts each buffered producer token to every
//   consumer selected by active_mask, delivering it exactly once per consumer,
//   and sequences mask changes so a token is never split across two masks.
//   Ports:
//     CLK, ASYNCRESET          clock, asynchronous active-high reset
//     in_valid/in_data/in_ready producer handshake into the skid buffer
//     out_valid/out_data/out_ready per-consumer handshake, shared data bus
//     cfg_wr/cfg_mask/cfg_busy  mask write request, new mask, write pending
//     flush                    synchronous clear of buffer and acceptance
//     active_mask              mask currently steering delivery
// ---------------------------------------------------------------------------
module fanout_fork_ctrl
    import fanout_fork_pkg::*;
#(
    parameter int NUM_OUT   = NUM_OUT_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic               CLK,
    input  logic               ASYNCRESET,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic [NUM_OUT-1:0] out_ready,
    input  logic               cfg_wr,
    input  logic [NUM_OUT-1:0] cfg_mask,
    output logic               cfg_busy,
    input  logic               flush,
    output logic [NUM_OUT-1:0] active_mask
);

    cfg_state_t         state;
    cfg_state_t         state_n;
    logic [NUM_OUT-1:0] active_n;
    logic [NUM_OUT-1:0] pend_mask;
    logic [NUM_OUT-1:0] pend_n;
    logic [NUM_OUT-1:0] accepted;
    logic [NUM_OUT-1:0] handshake;

    logic buf_full;
    logic buf_empty;
    logic head_v;
    logic push;
    logic pop;
    logic partial;
    logic run_safe;
    logic pend_safe;

    fanout_fork_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk     (CLK),
        .rst     (ASYNCRESET),
        .push    (push),
        .data_in (in_data),
        .pop     (pop),
        .flush   (flush),
        .full    (buf_full),
        .empty   (buf_empty),
        .head    (out_data)
    );

    // in_ready comes straight from buffer occupancy so there is no
    // combinational path from consumer readiness back to the producer.
    assign in_ready = ~buf_full;
    assign push     = in_valid & in_ready;
    assign head_v   = ~buf_empty;

    assign out_valid = {NUM_OUT{head_v}} & active_mask & ~accepted;
    assign handshake = out_valid & out_ready;
    assign pop       = head_v & all_done(active_mask, accepted, out_ready);

    // A token is "in flight" once some consumer has taken it but the fork
    // has not yet completed; switching the mask then would split it.
    assign partial   = (|handshake) & ~pop;
    assign run_safe  = flush | (~(|accepted) & ~partial);
    // In PEND the completing pop itself is a safe boundary: the new mask is
    // in place before the next token can start delivery.
    assign pend_safe = flush | pop | (~(|accepted) & ~partial);

    assign cfg_busy = (state == PEND);

    // Acceptance tracking: cleared when the token leaves (or on flush),
    // otherwise accumulates consumers that took the token this cycle.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            accepted <= '0;
        end else if (flush || pop) begin
            accepted <= '0;
        end else begin
            accepted <= accepted | handshake;
        end
    end

    // Configuration sequencer state and mask registers.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state       <= RUN;
            active_mask <= '0;
            pend_mask   <= '0;
        end else begin
            state       <= state_n;
            active_mask <= active_n;
            pend_mask   <= pend_n;
        end
    end

    // Next-state logic: a write in PEND simply replaces the held mask, and
    // when the write lands on the applying edge the newest mask is used.
    always_comb begin
        state_n  = state;
        active_n = active_mask;
        pend_n   = pend_mask;
        case (state)
            RUN: begin
                if (cfg_wr) begin
                    if (run_safe) begin
                        active_n = cfg_mask;
                    end else begin
                        pend_n  = cfg_mask;
                        state_n = PEND;
                    end
                end
            end
            PEND: begin
                if (cfg_wr) begin
                    pend_n = cfg_mask;
                end
                if (pend_safe) begin
                    active_n = cfg_wr ? cfg_mask : pend_mask;
                    state_n  = RUN;
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fanout_fork_ctrl
//   Directed, table-driven bench for fanout_fork_ctrl. Each table row holds
//   the inputs for one clock cycle and the outputs expected during that
//   cycle (before the edge that consumes the inputs). A hand-written sequence
//   afterwards covers asynchronous reset asserted between clock edges.
// ---------------------------------------------------------------------------
module tb_fanout_fork_ctrl;

    localparam int NOUT = 6;
    localparam int DW   = 17;

    logic            CLK;
    logic            ASYNCRESET;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic [NOUT-1:0] out_valid;
    logic [DW-1:0]   out_data;
    logic [NOUT-1:0] out_ready;
    logic            cfg_wr;
    logic [NOUT-1:0] cfg_mask;
    logic            cfg_busy;
    logic            flush;
    logic [NOUT-1:0] active_mask;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic            iv;
        logic [DW-1:0]   idata;
        logic [NOUT-1:0] ordy;
        logic            wr;
        logic [NOUT-1:0] cmask;
        logic            fl;
        logic            e_inrdy;
        logic [NOUT-1:0] e_ov;
        logic [DW-1:0]   e_od;
        logic            e_busy;
        logic [NOUT-1:0] e_am;
    } vec_t;

    vec_t vecs[$];

    fanout_fork_ctrl #(
        .NUM_OUT   (NOUT),
        .DATA_W    (DW),
        .BUF_DEPTH (2)
    ) dut (
        .CLK         (CLK),
        .ASYNCRESET  (ASYNCRESET),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .cfg_wr      (cfg_wr),
        .cfg_mask    (cfg_mask),
        .cfg_busy    (cfg_busy),
        .flush       (flush),
        .active_mask (active_mask)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(
        input logic iv, input logic [DW-1:0] idata, input logic [NOUT-1:0] ordy,
        input logic wr, input logic [NOUT-1:0] cmask, input logic fl,
        input logic e_inrdy, input logic [NOUT-1:0] e_ov, input logic [DW-1:0] e_od,
        input logic e_busy, input logic [NOUT-1:0] e_am
    );
        vec_t v;
        v.iv = iv;  v.idata = idata;  v.ordy = ordy;
        v.wr = wr;  v.cmask = cmask;  v.fl = fl;
        v.e_inrdy = e_inrdy;  v.e_ov = e_ov;  v.e_od = e_od;
        v.e_busy = e_busy;  v.e_am = e_am;
        return v;
    endfunction

    task automatic check_field(input string name, input int row,
                               input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(posedge CLK);
        #1;
        in_valid  = v.iv;
        in_data   = v.idata;
        out_ready = v.ordy;
        cfg_wr    = v.wr;
        cfg_mask  = v.cmask;
        flush     = v.fl;
    endtask

    task automatic check_output(input vec_t v, input int row);
        @(negedge CLK);
        check_field("in_ready",    row, 32'(in_ready),    32'(v.e_inrdy));
        check_field("out_valid",   row, 32'(out_valid),   32'(v.e_ov));
        check_field("out_data",    row, 32'(out_data),    32'(v.e_od));
        check_field("cfg_busy",    row, 32'(cfg_busy),    32'(v.e_busy));
        check_field("active_mask", row, 32'(active_mask), 32'(v.e_am));
    endtask

    initial begin
        //           iv idata    ordy   wr cmask  fl | rdy ov     od       bsy am
        // Broadcast to ports 0-2, one pop per cycle
        vecs.push_back(mk(0, 17'h000, 6'h3F, 1, 6'h07, 0, 1, 6'h00, 17'h000, 0, 6'h00));
        vecs.push_back(mk(1, 17'h001, 6'h3F, 0, 6'h00, 0, 1, 6'h00, 17'h000, 0, 6'h07));
        vecs.push_back(mk(1, 17'h002, 6'h3F, 0, 6'h00, 0, 1, 6'h07, 17'h001, 0, 6'h07));
        vecs.push_back(mk(1, 17'h003, 6'h3F, 0, 6'h00, 0, 1, 6'h07, 17'h002, 0, 6'h07));
        vecs.push_back(mk(1, 17'h004, 6'h3F, 0, 6'h00, 0, 1, 6'h07, 17'h003, 0, 6'h07));
        vecs.push_back(mk(0, 17'h000, 6'h3F, 0, 6'h00, 0, 1, 6'h07, 17'h004, 0, 6'h07));
        vecs.push_back(mk(0, 17'h000, 6'h3F, 0, 6'h00, 0, 1, 6'h00, 17'h004, 0, 6'h07));
        // Staggered ready on ports 0-1
        vecs.push_back(mk(0, 17'h000, 6'h3F, 1, 6'h03, 0, 1, 6'h00, 17'h004, 0, 6'h07));
        vecs.push_back(mk(1, 17'h0AA, 6'h01, 0, 6'h00, 0, 1, 6'h00, 17'h004, 0, 6'h03));
        vecs.push_back(mk(0, 17'h000, 6'h01, 0, 6'h00, 0, 1, 6'h03, 17'h0AA, 0, 6'h03));
        vecs.push_back(mk(0, 17'h000, 6'h01, 0, 6'h00, 0, 1, 6'h02, 17'h0AA, 0, 6'h03));
        vecs.push_back(mk(0, 17'h000, 6'h01, 0, 6'h00, 0, 1, 6'h02, 17'h0AA, 0, 6'h03));
        vecs.push_back(mk(0, 17'h000, 6'h03, 0, 6'h00, 0, 1, 6'h02, 17'h0AA, 0, 6'h03));
        vecs.push_back(mk(0, 17'h000, 6'h03, 0, 6'h00, 0, 1, 6'h00, 17'h0AA, 0, 6'h03));
        // Backpressure: buffer fills, third push refused, drains in order
        vecs.push_back(mk(1, 17'h010, 6'h00, 0, 6'h00, 0, 1, 6'h00, 17'h0AA, 0, 6'h03));
        vecs.push_back(mk(1, 17'h011, 6'h00, 0, 6'h00, 0, 1, 6'h03, 17'h010, 0, 6'h03));
        vecs.push_back(mk(1, 17'h012, 6'h00, 0, 6'h00, 0, 0, 6'h03, 17'h010, 0, 6'h03));
        vecs.push_back(mk(0, 17'h000, 6'h3F, 0, 6'h00, 0, 0, 6'h03, 17'h010, 0, 6'h03));
        vecs.push_back(mk(0, 17'h000, 6'h3F, 0, 6'h00, 0, 1, 6'h03, 17'h011, 0, 6'h03));
        vecs.push_back(mk(0, 17'h000, 6'h3F, 0, 6'h00, 0, 1, 6'h00, 17'h011, 0, 6'h03));
        // Mid-token reconfiguration to ports 4-5
        vecs.push_back(mk(1, 17'h020, 6'h01, 0, 6'h00, 0, 1, 6'h00, 17'h011, 0, 6'h03));
        vecs.push_back(mk(0, 17'h000, 6'h01, 0, 6'h00, 0, 1, 6'h03, 17'h020, 0, 6'h03));
        vecs.push_back(mk(1, 17'h021, 6'h01, 1, 6'h30, 0, 1, 6'h02, 17'h020, 0, 6'h03));
        vecs.push_back(mk(0, 17'h000, 6'h02, 0, 6'h00, 0, 0, 6'h02, 17'h020, 1, 6'h03));
        vecs.push_back(mk(0, 17'h000, 6'h30, 0, 6'h00, 0, 1, 6'h30, 17'h021, 0, 6'h30));
        vecs.push_back(mk(0, 17'h000, 6'h30, 0, 6'h00, 0, 1, 6'h00, 17'h021, 0, 6'h30));
        // Flush with two buffered tokens and a pending mask
        vecs.push_back(mk(1, 17'h030, 6'h00, 0, 6'h00, 0, 1, 6'h00, 17'h021, 0, 6'h30));
        vecs.push_back(mk(1, 17'h031, 6'h00, 0, 6'h00, 0, 1, 6'h30, 17'h030, 0, 6'h30));
        vecs.push_back(mk(0, 17'h000, 6'h10, 1, 6'h0C, 0, 0, 6'h30, 17'h030, 0, 6'h30));
        vecs.push_back(mk(1, 17'h032, 6'h00, 0, 6'h00, 1, 0, 6'h20, 17'h030, 1, 6'h30));
        vecs.push_back(mk(0, 17'h000, 6'h00, 0, 6'h00, 0, 1, 6'h00, 17'h030, 0, 6'h0C));
        // Zero mask: tokens discarded at one per cycle
        vecs.push_back(mk(0, 17'h000, 6'h00, 1, 6'h00, 0, 1, 6'h00, 17'h030, 0, 6'h0C));
        vecs.push_back(mk(1, 17'h040, 6'h00, 0, 6'h00, 0, 1, 6'h00, 17'h030, 0, 6'h00));
        vecs.push_back(mk(1, 17'h041, 6'h00, 0, 6'h00, 0, 1, 6'h00, 17'h040, 0, 6'h00));
        vecs.push_back(mk(1, 17'h042, 6'h00, 0, 6'h00, 0, 1, 6'h00, 17'h041, 0, 6'h00));
        vecs.push_back(mk(0, 17'h000, 6'h00, 0, 6'h00, 0, 1, 6'h00, 17'h042, 0, 6'h00));
        vecs.push_back(mk(0, 17'h000, 6'h00, 0, 6'h00, 0, 1, 6'h00, 17'h042, 0, 6'h00));

        ASYNCRESET = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = '0;
        cfg_wr     = 1'b0;
        cfg_mask   = '0;
        flush      = 1'b0;

        // Reset values while reset is held
        #11;
        check_field("reset_in_ready",    -1, 32'(in_ready),    32'h1);
        check_field("reset_out_valid",   -1, 32'(out_valid),   32'h0);
        check_field("reset_out_data",    -1, 32'(out_data),    32'h0);
        check_field("reset_cfg_busy",    -1, 32'(cfg_busy),    32'h0);
        check_field("reset_active_mask", -1, 32'(active_mask), 32'h0);
        #1;
        ASYNCRESET = 1'b0;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], i);
        end

        // Asynchronous reset asserted between edges while a token is offered
        apply_stimulus(mk(0, 17'h000, 6'h00, 1, 6'h3F, 0, 1, 6'h00, 17'h042, 0, 6'h00));
        check_output  (mk(0, 17'h000, 6'h00, 1, 6'h3F, 0, 1, 6'h00, 17'h042, 0, 6'h00), 100);
        apply_stimulus(mk(1, 17'h050, 6'h00, 0, 6'h00, 0, 1, 6'h00, 17'h042, 0, 6'h3F));
        check_output  (mk(1, 17'h050, 6'h00, 0, 6'h00, 0, 1, 6'h00, 17'h042, 0, 6'h3F), 101);
        apply_stimulus(mk(0, 17'h000, 6'h00, 0, 6'h00, 0, 1, 6'h3F, 17'h050, 0, 6'h3F));
        check_output  (mk(0, 17'h000, 6'h00, 0, 6'h00, 0, 1, 6'h3F, 17'h050, 0, 6'h3F), 102);

        ASYNCRESET = 1'b1;
        #1;
        check_field("async_out_valid",   103, 32'(out_valid),   32'h0);
        check_field("async_active_mask", 103, 32'(active_mask), 32'h0);
        check_field("async_out_data",    103, 32'(out_data),    32'h0);
        check_field("async_in_ready",    103, 32'(in_ready),    32'h1);
        #2;
        ASYNCRESET = 1'b0;

        // After reset the buffer is empty and nothing is offered
        apply_stimulus(mk(0, 17'h000, 6'h3F, 0, 6'h00, 0, 1, 6'h00, 17'h000, 0, 6'h00));
        check_output  (mk(0, 17'h000, 6'h3F, 0, 6'h00, 0, 1, 6'h00, 17'h000, 0, 6'h00), 104);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
